// File: rtl/text_tile_generator_pkg.sv
// text_tile_generator_pkg: cell/attribute layout, font geometry and FSM encoding
package text_tile_generator_pkg;
  localparam int CHAR_W = 7;
  localparam int ATTR_W = 7;
  localparam int CELL_W = CHAR_W + ATTR_W;
  localparam int FONT_W = 8;
  localparam int FONT_H = 16;
  localparam logic [CHAR_W-1:0] SPACE_CHAR = 7'h20;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  typedef struct packed {
    logic       blink;
    logic [2:0] bg;
    logic [2:0] fg;
  } attr_t;
  typedef struct packed {
    logic [CHAR_W-1:0] ch;
    attr_t             attr;
  } cell_t;
endpackage

// File: rtl/font_rom.sv
// font_rom: 8x16 glyph ROM, addr = {char, glyph row}, one-cycle registered read; bit 7 is the leftmost pixel
module font_rom (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);
  logic [127:0] g;
  function automatic logic [127:0] glyph(input logic [6:0] c);
    case (c)
      7'h30:   glyph = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
      7'h31:   glyph = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
      7'h41:   glyph = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
      7'h42:   glyph = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;
      7'h43:   glyph = 128'h0000_3C66_C2C0_C0C0_C0C2_663C_0000_0000;
      default: glyph = 128'h0;
    endcase
  endfunction
  assign g = glyph(addr[10:4]);
  always_ff @(posedge clk) data <= g[{~addr[3:0], 3'b000} +: 8];
endmodule

// File: rtl/text_tile_generator_cell_ram.sv
// text_cell_ram: simple dual-port cell buffer, one write port and one synchronous read-first read port
module text_cell_ram #(
  parameter int DEPTH = 140,
  parameter int W = 14
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/text_tile_generator.sv
// text_tile_generator: COLS x ROWS character overlay from a writable cell buffer, 3-cycle pixel pipeline
module text_tile_generator
  import text_tile_generator_pkg::*;
#(
  parameter int                COLS           = 20,
  parameter int                ROWS           = 7,
  parameter int                SCALE_LOG2     = 2,
  parameter int                BLINK_DIV_LOG2 = 25,
  parameter logic [ATTR_W-1:0] DEFAULT_ATTR   = 7'b0_111_011
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [9:0]              pix_x,
  input  logic [9:0]              pix_y,
  input  logic                    video_on,
  input  logic                    blink_en,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [$clog2(COLS)-1:0] wr_col,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [CHAR_W-1:0]       wr_char,
  input  logic [ATTR_W-1:0]       wr_attr,
  output logic                    wr_err,
  input  logic                    clear_req,
  output logic                    busy,
  output logic                    text_on,
  output logic [2:0]              text_rgb
);
  localparam int CELLS = COLS * ROWS;
  localparam int AW = $clog2(CELLS);
  state_t                  state;
  logic [AW-1:0]           clr_idx, wr_addr, rd_addr, ram_waddr;
  logic                    clr_last, wr_fire, wr_in_range, ram_we;
  cell_t                   ram_wdata, cell1;
  logic [9:0]              col0, row0;
  logic                    in0, in1, in2;
  logic [3:0]              font_row1;
  logic [2:0]              bit1, bit2;
  attr_t                   attr2;
  logic [FONT_W-1:0]       font_word;
  logic [BLINK_DIV_LOG2:0] blink_cnt;
  logic                    font_bit, blink_off;

  assign wr_ready    = state == ST_IDLE && !clear_req && reset_n;
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = 32'(wr_col) < COLS && 32'(wr_row) < ROWS;
  assign wr_addr     = AW'(wr_row) * AW'(COLS) + AW'(wr_col);
  assign clr_last    = clr_idx == AW'(CELLS - 1);
  assign ram_we      = state == ST_CLEAR || (wr_fire && wr_in_range);
  assign ram_waddr   = state == ST_CLEAR ? clr_idx : wr_addr;
  assign ram_wdata   = state == ST_CLEAR ? cell_t'({SPACE_CHAR, DEFAULT_ATTR}) : cell_t'({wr_char, wr_attr});

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= ST_CLEAR;
      busy    <= 1'b1;
      clr_idx <= '0;
      wr_err  <= 1'b0;
    end else begin
      wr_err <= wr_fire && !wr_in_range;
      if (state == ST_CLEAR) begin
        state   <= clr_last ? ST_IDLE : ST_CLEAR;
        busy    <= !clr_last;
        clr_idx <= clr_last ? '0 : clr_idx + 1'b1;
      end else if (clear_req) begin
        state   <= ST_CLEAR;
        busy    <= 1'b1;
        clr_idx <= '0;
      end
    end

  text_cell_ram #(.DEPTH(CELLS), .W(CELL_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (cell1)
  );

  font_rom u_font (
    .clk  (clk),
    .addr ({cell1.ch, font_row1}),
    .data (font_word)
  );

  assign col0    = pix_x >> (3 + SCALE_LOG2);
  assign row0    = pix_y >> (4 + SCALE_LOG2);
  assign in0     = video_on && 32'(col0) < COLS && 32'(row0) < ROWS;
  assign rd_addr = AW'(row0) * AW'(COLS) + AW'(col0);

  // font bit 7 is the leftmost pixel of the glyph row
  assign font_bit  = font_word[~bit2];
  assign blink_off = attr2.blink && blink_en && blink_cnt[BLINK_DIV_LOG2];

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      in1       <= 1'b0;
      in2       <= 1'b0;
      font_row1 <= '0;
      bit1      <= '0;
      bit2      <= '0;
      attr2     <= '0;
      text_on   <= 1'b0;
      text_rgb  <= '0;
      blink_cnt <= '0;
    end else begin
      in1       <= in0;
      font_row1 <= pix_y[SCALE_LOG2+3:SCALE_LOG2];
      bit1      <= pix_x[SCALE_LOG2+2:SCALE_LOG2];
      in2       <= in1;
      bit2      <= bit1;
      attr2     <= cell1.attr;
      text_on   <= in2;
      text_rgb  <= !in2 ? 3'b000 : font_bit && !blink_off ? attr2.fg : attr2.bg;
      blink_cnt <= blink_en ? blink_cnt + 1'b1 : '0;
    end
endmodule

// File: tb/tb_text_tile_generator.sv
// tb_text_tile_generator: directed tests of clear, writes, glyph rendering, grid bounds and blink
module tb_text_tile_generator;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic [9:0] pix_x = '0, pix_y = '0;
  logic       video_on = 1'b0, blink_en = 1'b0, wr_valid = 1'b0, clear_req = 1'b0;
  logic [4:0] wr_col = '0;
  logic [2:0] wr_row = '0;
  logic [6:0] wr_char = '0, wr_attr = '0;
  logic       wr_ready, wr_err, busy, text_on;
  logic [2:0] text_rgb;
  int         checks = 0, failures = 0;
  logic [7:0] glyph_a [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                               8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};

  always #5 clk = ~clk;

  text_tile_generator #(.BLINK_DIV_LOG2(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .video_on  (video_on),
    .blink_en  (blink_en),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_col    (wr_col),
    .wr_row    (wr_row),
    .wr_char   (wr_char),
    .wr_attr   (wr_attr),
    .wr_err    (wr_err),
    .clear_req (clear_req),
    .busy      (busy),
    .text_on   (text_on),
    .text_rgb  (text_rgb)
  );

  task automatic set_pix(input int x, input int y, input logic v);
    pix_x = 10'(x);
    pix_y = 10'(y);
    video_on = v;
  endtask

  task automatic drive_write(input int col, input int row, input logic [6:0] ch, input logic [6:0] attr);
    wr_valid = 1'b1;
    wr_col = 5'(col);
    wr_row = 3'(row);
    wr_char = ch;
    wr_attr = attr;
  endtask

  task automatic count_busy(input int pulse_at, output int n, output int rdy);
    n = 0;
    rdy = 0;
    while (busy === 1'b1 && n < 1000) begin
      clear_req = (n == pulse_at);
      #1;
      if (wr_ready !== 1'b0) rdy++;
      n++;
      @(negedge clk);
    end
    clear_req = 1'b0;
  endtask

  task automatic test_reset();
    int n, rdy;
    repeat (2) @(negedge clk);
    checks++;
    if (text_rgb !== 3'b000 || text_on !== 1'b0 || wr_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs rgb=%b on=%b err=%b want 000/0/0", text_rgb, text_on, wr_err);
    end
    checks++;
    if (busy !== 1'b1 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy busy=%b ready=%b want 1/0", busy, wr_ready);
    end
    reset_n = 1'b1;
    count_busy(-1, n, rdy);
    checks++;
    if (n !== 140) begin
      failures++;
      $display("FAIL reset_busy_len got=%0d want=140", n);
    end
    checks++;
    if (rdy !== 0) begin
      failures++;
      $display("FAIL reset_ready_during_clear got=%0d want=0", rdy);
    end
  endtask

  task automatic test_blank();
    int px [4] = '{0, 100, 639, 320};
    int py [4] = '{0, 50, 447, 200};
    for (int i = 0; i < 4; i++) begin
      set_pix(px[i], py[i], 1'b1);
      repeat (3) @(negedge clk);
      checks++;
      if (text_rgb !== 3'b111 || text_on !== 1'b1) begin
        failures++;
        $display("FAIL blank_%0d rgb=%b on=%b want 111/1", i, text_rgb, text_on);
      end
    end
  endtask

  task automatic test_out_of_grid();
    int   px [3] = '{10, 640, 100};
    int   py [3] = '{460, 10, 100};
    logic pv [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      set_pix(0, 0, 1'b1);
      repeat (3) @(negedge clk);
      set_pix(px[i], py[i], pv[i]);
      repeat (3) @(negedge clk);
      checks++;
      if (text_rgb !== 3'b000 || text_on !== 1'b0) begin
        failures++;
        $display("FAIL out_of_grid_%0d rgb=%b on=%b want 000/0", i, text_rgb, text_on);
      end
    end
  endtask

  task automatic test_write_glyph();
    logic [2:0] exp_q [$];
    logic [2:0] e;
    logic [7:0] r;
    int         i;
    drive_write(2, 3, 7'h41, 7'b0_111_011);
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL write_ready got=%b want=1", wr_ready);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    checks++;
    if (wr_err !== 1'b0) begin
      failures++;
      $display("FAIL write_err_inrange got=%b want=0", wr_err);
    end
    i = 0;
    for (int y = 192; y < 256; y++)
      for (int x = 64; x < 96; x++) begin
        if (i >= 3) begin
          e = exp_q.pop_front();
          checks++;
          if (text_rgb !== e || text_on !== 1'b1) begin
            failures++;
            $display("FAIL glyph_sweep idx=%0d rgb=%b on=%b want %b/1", i - 3, text_rgb, text_on, e);
          end
        end
        set_pix(x, y, 1'b1);
        r = glyph_a[(y - 192) >> 2];
        exp_q.push_back(r[7 - ((x - 64) >> 2)] ? 3'b011 : 3'b111);
        i++;
        @(negedge clk);
      end
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (text_rgb !== e || text_on !== 1'b1) begin
        failures++;
        $display("FAIL glyph_sweep_tail k=%0d rgb=%b on=%b want %b/1", k, text_rgb, text_on, e);
      end
      @(negedge clk);
    end
    set_pix(100, 220, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (text_rgb !== 3'b111) begin
      failures++;
      $display("FAIL glyph_neighbour rgb=%b want=111", text_rgb);
    end
  endtask

  task automatic test_wr_err();
    int wc [2] = '{0, 20};
    int wrr [2] = '{7, 0};
    for (int i = 0; i < 2; i++) begin
      drive_write(wc[i], wrr[i], 7'h41, 7'b0_111_011);
      #1;
      checks++;
      if (wr_ready !== 1'b1) begin
        failures++;
        $display("FAIL err_ready_%0d got=%b want=1", i, wr_ready);
      end
      @(negedge clk);
      wr_valid = 1'b0;
      checks++;
      if (wr_err !== 1'b1) begin
        failures++;
        $display("FAIL err_pulse_%0d got=%b want=1", i, wr_err);
      end
      @(negedge clk);
      checks++;
      if (wr_err !== 1'b0) begin
        failures++;
        $display("FAIL err_one_cycle_%0d got=%b want=0", i, wr_err);
      end
    end
    set_pix(4, 92, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (text_rgb !== 3'b111) begin
      failures++;
      $display("FAIL err_no_alias rgb=%b want=111", text_rgb);
    end
  endtask

  task automatic test_blink();
    logic [2:0] e;
    drive_write(0, 0, 7'h41, 7'b1_111_011);
    @(negedge clk);
    wr_valid = 1'b0;
    set_pix(4, 28, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (text_rgb !== 3'b011) begin
      failures++;
      $display("FAIL blink_pre rgb=%b want=011", text_rgb);
    end
    blink_en = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      e = ((k - 1) % 32) >= 16 ? 3'b111 : 3'b011;
      checks++;
      if (text_rgb !== e) begin
        failures++;
        $display("FAIL blink_phase k=%0d rgb=%b want=%b", k, text_rgb, e);
      end
    end
    blink_en = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if (text_rgb !== 3'b011) begin
        failures++;
        $display("FAIL blink_off k=%0d rgb=%b want=011", k, text_rgb);
      end
    end
    checks++;
    if (dut.blink_cnt !== '0) begin
      failures++;
      $display("FAIL blink_cnt_zero got=%0d want=0", dut.blink_cnt);
    end
  endtask

  task automatic test_clear_collision();
    int n, rdy;
    clear_req = 1'b1;
    drive_write(0, 7, 7'h41, 7'b0_111_011);
    #1;
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL collide_ready got=%b want=0", wr_ready);
    end
    @(negedge clk);
    clear_req = 1'b0;
    wr_valid = 1'b0;
    checks++;
    if (wr_err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL collide_state err=%b busy=%b want 0/1", wr_err, busy);
    end
    count_busy(70, n, rdy);
    checks++;
    if (n !== 140 || rdy !== 0) begin
      failures++;
      $display("FAIL collide_busy_len got=%0d ready_hi=%0d want 140/0", n, rdy);
    end
    set_pix(68, 220, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (text_rgb !== 3'b111) begin
      failures++;
      $display("FAIL collide_cleared_glyph rgb=%b want=111", text_rgb);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n, rdy;
    set_pix(0, 0, 1'b1);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (50) @(negedge clk);
    checks++;
    if (text_on !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midclear_pre on=%b busy=%b want 1/1", text_on, busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (text_rgb !== 3'b000 || text_on !== 1'b0 || wr_err !== 1'b0 || wr_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midclear_reset rgb=%b on=%b err=%b ready=%b busy=%b want 000/0/0/0/1",
               text_rgb, text_on, wr_err, wr_ready, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    count_busy(-1, n, rdy);
    checks++;
    if (n !== 140 || rdy !== 0) begin
      failures++;
      $display("FAIL midclear_busy_len got=%0d ready_hi=%0d want 140/0", n, rdy);
    end
  endtask

  initial begin
    test_reset();
    test_blank();
    test_out_of_grid();
    test_write_glyph();
    test_wr_err();
    test_blink();
    test_clear_collision();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/text_tile_generator.md
Name: text_tile_generator

Overview:
Parametrised successor to the fixed-layout VGA text generator. It draws a COLS x ROWS grid of characters from an internal, writable cell buffer. Each cell holds a character code and a colour/blink attribute, and the controller updates cells through a valid/ready write port instead of hard-wired per-field decode. The block sits between the VGA sync counter (pix_x/pix_y) and the RGB output mux. It reuses the existing font_rom (8x16, synchronous read).

Parameters:
COLS, 20, character columns in the grid
ROWS, 7, character rows in the grid
SCALE_LOG2, 2, log2 of screen pixels per font pixel; cell = (8<<SCALE_LOG2) x (16<<SCALE_LOG2) screen pixels
BLINK_DIV_LOG2, 25, blink half-period = 2^BLINK_DIV_LOG2 clk cycles
DEFAULT_ATTR, 7'b0_111_011, attribute written by clear: {blink, bg[2:0], fg[2:0]}

Ports:
clk  in  1  pixel/system clock
reset_n  in  1  asynchronous, active-low reset
pix_x  in  10  current pixel column
pix_y  in  10  current pixel row
video_on  in  1  visible-area flag, aligned with pix_x/pix_y
blink_en  in  1  global blink enable (alarm active)
wr_valid  in  1  cell write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_col  in  $clog2(COLS)  target column
wr_row  in  $clog2(ROWS)  target row
wr_char  in  7  ASCII code
wr_attr  in  7  {blink, bg[2:0], fg[2:0]}
wr_err  out  1  one-cycle pulse: accepted write was out of range and discarded
clear_req  in  1  pulse: fill the whole buffer with 7'h20 and DEFAULT_ATTR
busy  out  1  clear in progress
text_on  out  1  output pixel lies inside the grid
text_rgb  out  3  output colour

Behaviour:
- Reset (async, reset_n=0): text_rgb=0, text_on=0, wr_err=0, wr_ready=0, blink counter=0, pipeline valid bits=0, FSM=CLEAR with clear index 0, busy=1.
- FSM IDLE/CLEAR:
  - CLEAR writes one cell per cycle (index 0..COLS*ROWS-1), then moves to IDLE.
  - IDLE -> CLEAR on clear_req; clear_req during CLEAR is ignored.
  - busy=(state==CLEAR).
  - wr_ready = (state==IDLE) && !clear_req && reset_n, combinational. clear_req wins over a simultaneous wr_valid.
- Write: on handshake, if wr_col<COLS and wr_row<ROWS, write cell row*COLS+col; otherwise discard and pulse wr_err on the next cycle.
- Cell RAM: dual-port, write port plus synchronous read port, read-first. A same-cycle read of the written address returns the old value.
- Display pipeline, fixed latency 3 cycles from pix_x/pix_y/video_on to text_rgb/text_on. Downstream must delay hsync/vsync by 3.
  - S0: col = pix_x>>(3+SCALE_LOG2); row = pix_y>>(4+SCALE_LOG2); in_grid = video_on && col<COLS && row<ROWS; issue cell read; register font_row = pix_y[SCALE_LOG2+3:SCALE_LOG2], bit = pix_x[SCALE_LOG2+2:SCALE_LOG2], in_grid.
  - S1: font_rom addr = {char, font_row}; register attr, bit, in_grid.
  - S2: font_bit = font_word[~bit].
    - !in_grid -> text_on=0, rgb=000.
    - font_bit && !(attr.blink && blink_en && phase) -> fg.
    - otherwise -> bg, text_on=1.
- Blink counter: BLINK_DIV_LOG2+1 bits, increments while blink_en=1, cleared to 0 while blink_en=0; phase = MSB. Phase 0 shows fg.
- Display continues during CLEAR and shows partially cleared contents.
- Reset mid-clear aborts the clear; the clear restarts from index 0 after release.

Decomposition:
- Shared package: ATTR field positions, SPACE_CHAR=7'h20, FONT_W=8, FONT_H=16, state encoding.
- Sub-module text_cell_ram: parametrised depth COLS*ROWS, width 14, 1 write + 1 sync read port, read-first.
- font_rom is instantiated unchanged.

Test Plan:
- Reset release -> busy=1 for exactly 140 cycles, wr_ready=0 throughout; afterwards any in-grid pixel shows text_rgb=011 (fg DEFAULT_ATTR) on space glyph set bits, otherwise 111, text_on=1.
- Write wr_char=7'h41, wr_attr=7'b0_111_011 at col 2 row 3; sweep pix_x 64..95, pix_y 192..255 -> 3 cycles later rgb=011 exactly where font_rom(0x41) bits are 1, 111 elsewhere.
- pix_y=460 (row 7 >= ROWS) or video_on=0 -> text_on=0, text_rgb=000 after 3 cycles.
- BLINK_DIV_LOG2=4, blink-attr cell, blink_en=1 -> glyph pixels alternate 011/111 every 16 cycles; blink_en=0 -> steady 011, counter reads 0.
- wr_row=7, wr_valid=1 -> handshake completes, wr_err=1 for one cycle, no cell changed; clear_req with wr_valid the same cycle -> wr_ready=0, write not taken, busy for 140 cycles.
- Assert reset_n=0 at clear index 50 -> outputs 0 immediately; after release, busy=1 for a full 140 cycles.
